unified_mem_arbiter: RTL

- Arbitrates the single shared instruction/data memory port between two requesters: IF-stage fetch (pcF) and MEM-stage load/store (aluoutM / mem_WriteData).
- Sequences variable-latency memory transactions with a req/ack handshake.
- Generates stall signals that feed the hazard unit (OR'd into stallF / whole-pipeline freeze).
- Sits between the pipelined datapath and the memory model; replaces separate instruction and data memories.

---
 rtl/unified_mem_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data load/store,
// sequencing req/ack transactions and producing pipeline stall requests.
module unified_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall_if,
    output logic          stall_dm,
    output logic          err_ack
);

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        DM_BUSY
    } ArbState;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

    ArbState    state;
    ArbState    nextState;
    logic [3:0] starveCnt;
    logic [3:0] starveCntNext;
    logic       ifElig;
    logic       dmElig;
    logic       ifCand;
    logic       dmCand;
    logic       decide;
    logic       grantIf;
    logic       grantDm;
    logic       ifAck;
    logic       dmAck;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            starveCnt <= 4'd0;
        end else begin
            state     <= nextState;
            starveCnt <= starveCntNext;
        end
    end

    // A request held through its own ready cycle is not yet a new request, and the
    // requester just served is excluded from the decision taken in its ack cycle.
    always_comb begin
        ifElig        = if_req & ~if_ready;
        dmElig        = dm_req & ~dm_ready;
        ifAck         = (state == IF_BUSY) & mem_ack;
        dmAck         = (state == DM_BUSY) & mem_ack;
        decide        = (state == IDLE) | ifAck | dmAck;
        ifCand        = ifElig & (state != IF_BUSY);
        dmCand        = dmElig & (state != DM_BUSY);
        grantDm       = decide & dmCand & (~ifCand | (starveCnt != STARVE_MAX));
        grantIf       = decide & ifCand & ~grantDm;
        nextState     = state;
        starveCntNext = starveCnt;
        if (decide) begin
            if (grantDm) begin
                nextState = DM_BUSY;
            end else if (grantIf) begin
                nextState = IF_BUSY;
            end else begin
                nextState = IDLE;
            end
        end
        if (grantIf) begin
            starveCntNext = 4'd0;
        end else if (grantDm && ifCand && (starveCnt != STARVE_MAX)) begin
            starveCntNext = starveCnt + 4'd1;
        end
    end

    // Memory-side outputs are latched at grant time so they stay stable until ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            err_ack   <= 1'b0;
        end else begin
            if_ready <= ifAck & if_req;
            dm_ready <= dmAck & dm_req;
            if (ifAck) begin
                if_rdata <= mem_rdata;
            end
            if (dmAck) begin
                dm_rdata <= mem_rdata;
            end
            if ((state == IDLE) && mem_ack) begin
                err_ack <= 1'b1;
            end
            if (grantDm) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (grantIf) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
            end else if (decide) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
        end
    end

    assign stall_if = if_req & ~if_ready;
    assign stall_dm = dm_req & ~dm_ready;

endmodule
